// File: rtl/delay_path_sensor.sv
// Tapped delay-path sensor controller: launches an edge into an external delay chain,
// captures and decodes the tap vector, and reports sum/avg/min/max over 2^SAMPLES_LOG2 launches.
module delay_path_sensor #(
  parameter int                N_TAPS        = 8,
  parameter logic [N_TAPS-1:0] TAP_POL       = '0,
  parameter int                SETTLE_CYCLES = 2,
  parameter int                SAMPLES_LOG2  = 2,
  localparam int               CW            = $clog2(N_TAPS + 1),
  localparam int               SW            = CW + SAMPLES_LOG2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              cont_i,
  output logic              launch_o,
  input  logic [N_TAPS-1:0] taps_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [SW-1:0]     sum_o,
  output logic [CW-1:0]     avg_o,
  output logic [CW-1:0]     min_o,
  output logic [CW-1:0]     max_o,
  output logic              bubble_o,
  output logic              ovf_o
);

  localparam int STW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int SCW = (SAMPLES_LOG2 > 0) ? SAMPLES_LOG2 : 1;
  localparam logic [SCW-1:0] LAST_SAMPLE = SCW'((1 << SAMPLES_LOG2) - 1);
  localparam logic [STW-1:0] SETTLE_LOAD = STW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, SETTLE, LAUNCH, CAP, ACC, DONE} state_t;

  state_t            state;
  logic [N_TAPS-1:0] cap1, cap2;
  logic [STW-1:0]    settle_cnt;
  logic [SCW-1:0]    sample_cnt;
  logic [SW-1:0]     acc_sum;
  logic [CW-1:0]     acc_min, acc_max;
  logic              acc_bubble, acc_ovf;

  logic [CW-1:0]     count;
  logic              bubble_now, ovf_now;
  logic [SW-1:0]     sum_nx;
  logic [CW-1:0]     min_nx, max_nx;

  // Two-flop capture of the asynchronous taps, with polarity correction folded in
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap1 <= '0;
      cap2 <= '0;
    end else begin
      cap1 <= taps_i ^ TAP_POL;
      cap2 <= cap1;
    end
  end

  // A valid pattern has ones contiguous from tap 0, so adding one carries cleanly past them
  always_comb begin
    count = '0;
    for (int i = 0; i < N_TAPS; i++) count = count + CW'(cap2[i]);
    bubble_now = |({1'b0, cap2} & ({1'b0, cap2} + {{N_TAPS{1'b0}}, 1'b1}));
    ovf_now    = (count == CW'(N_TAPS));
    sum_nx     = acc_sum + SW'(count);
    min_nx     = (count < acc_min) ? count : acc_min;
    max_nx     = (count > acc_max) ? count : acc_max;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      settle_cnt <= '0;
      sample_cnt <= '0;
      acc_sum    <= '0;
      acc_min    <= '0;
      acc_max    <= '0;
      acc_bubble <= 1'b0;
      acc_ovf    <= 1'b0;
      launch_o   <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      sum_o      <= '0;
      avg_o      <= '0;
      min_o      <= '0;
      max_o      <= '0;
      bubble_o   <= 1'b0;
      ovf_o      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          launch_o <= 1'b0;
          if (start_i) begin
            acc_sum    <= '0;
            acc_min    <= '1;
            acc_max    <= '0;
            acc_bubble <= 1'b0;
            acc_ovf    <= 1'b0;
            sample_cnt <= '0;
            settle_cnt <= SETTLE_LOAD;
            busy_o     <= 1'b1;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_cnt == '0) begin
            launch_o <= 1'b1;
            state    <= LAUNCH;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        LAUNCH: state <= CAP;
        CAP: begin
          launch_o <= 1'b0;
          state    <= ACC;
        end
        // Results load together with done so readers see them on the pulse itself
        ACC: begin
          acc_sum    <= sum_nx;
          acc_min    <= min_nx;
          acc_max    <= max_nx;
          acc_bubble <= acc_bubble | bubble_now;
          acc_ovf    <= acc_ovf | ovf_now;
          if (sample_cnt == LAST_SAMPLE) begin
            sum_o    <= sum_nx;
            avg_o    <= CW'(sum_nx >> SAMPLES_LOG2);
            min_o    <= min_nx;
            max_o    <= max_nx;
            bubble_o <= acc_bubble | bubble_now;
            ovf_o    <= acc_ovf | ovf_now;
            done_o   <= 1'b1;
            state    <= DONE;
          end else begin
            sample_cnt <= sample_cnt + 1'b1;
            settle_cnt <= SETTLE_LOAD;
            state      <= SETTLE;
          end
        end
        DONE: begin
          done_o <= 1'b0;
          if (cont_i) begin
            acc_sum    <= '0;
            acc_min    <= '1;
            acc_max    <= '0;
            acc_bubble <= 1'b0;
            acc_ovf    <= 1'b0;
            sample_cnt <= '0;
            settle_cnt <= SETTLE_LOAD;
            state      <= SETTLE;
          end else begin
            busy_o <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          launch_o <= 1'b0;
          busy_o   <= 1'b0;
          done_o   <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_delay_path_sensor.sv
// Self-checking bench for delay_path_sensor: directed vector table, randomized launches
// against a popcount-based reference model, and reset / continuous-mode sequences.
module tb_delay_path_sensor;

  localparam int N_TAPS        = 8;
  localparam int SETTLE_CYCLES = 2;
  localparam int NS            = 4;
  localparam int LATENCY       = NS * (SETTLE_CYCLES + 3);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_i = 1'b0;
  logic       cont_i = 1'b0;
  logic       launch_o;
  logic [7:0] taps_i;
  logic       busy_o, done_o;
  logic [5:0] sum_o;
  logic [3:0] avg_o, min_o, max_o;
  logic       bubble_o, ovf_o;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] cur_pats = '0;
  int          launch_idx = 0;
  int          launch_cycles = 0;

  delay_path_sensor #(
    .N_TAPS(8), .TAP_POL(8'h00), .SETTLE_CYCLES(2), .SAMPLES_LOG2(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .cont_i(cont_i),
    .launch_o(launch_o), .taps_i(taps_i), .busy_o(busy_o), .done_o(done_o),
    .sum_o(sum_o), .avg_o(avg_o), .min_o(min_o), .max_o(max_o),
    .bubble_o(bubble_o), .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  // The chain model: byte k of cur_pats is what the taps show during launch k
  assign taps_i = launch_o ? cur_pats[8*(launch_idx%4) +: 8] : 8'h00;
  always @(negedge launch_o) launch_idx++;
  always @(posedge clk) if (launch_o) launch_cycles++;

  typedef struct {
    string       name;
    logic [31:0] pats;
    int          sum, avg, mn, mx, bub, ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t model(input string name, input logic [31:0] pats);
    vec_t v;
    v.name = name; v.pats = pats;
    v.sum = 0; v.mn = N_TAPS; v.mx = 0; v.bub = 0; v.ovf = 0;
    for (int k = 0; k < NS; k++) begin
      logic [7:0] p;
      int c;
      p = pats[8*k +: 8];
      c = $countones(p);
      if (int'(p) != (1 << c) - 1) v.bub = 1;
      if (c == N_TAPS) v.ovf = 1;
      v.sum += c;
      if (c < v.mn) v.mn = c;
      if (c > v.mx) v.mx = c;
    end
    v.avg = v.sum / NS;
    return v;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual != expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] pats, output int lat, output bit got);
    cur_pats = pats;
    launch_idx = 0;
    launch_cycles = 0;
    @(negedge clk);
    start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 4 * LATENCY) begin
      @(posedge clk);
      lat++;
      #1;
      if (done_o) got = 1'b1;
    end
  endtask

  task automatic checkResults(input vec_t v, input int lat, input bit got);
    checkOutput({v.name, " done_seen"}, int'(got), 1);
    if (got) begin
      checkOutput({v.name, " latency"}, lat, LATENCY);
      checkOutput({v.name, " sum"}, sum_o, v.sum);
      checkOutput({v.name, " avg"}, avg_o, v.avg);
      checkOutput({v.name, " min"}, min_o, v.mn);
      checkOutput({v.name, " max"}, max_o, v.mx);
      checkOutput({v.name, " bubble"}, bubble_o, v.bub);
      checkOutput({v.name, " ovf"}, ovf_o, v.ovf);
      checkOutput({v.name, " launch_cycles"}, launch_cycles, 2 * NS);
    end
  endtask

  task automatic runVector(input vec_t v);
    int lat;
    bit got;
    applyStimulus(v.pats, lat, got);
    checkResults(v, lat, got);
    @(posedge clk);
    #1;
    checkOutput({v.name, " done_pulse_width"}, done_o, 0);
    checkOutput({v.name, " busy_after"}, busy_o, 0);
    checkOutput({v.name, " sum_held"}, sum_o, v.sum);
  endtask

  initial begin
    vec_t v;
    int   lat, cyc, dones;
    bit   got;
    logic [31:0] pats;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset launch", launch_o, 0);
    checkOutput("reset busy", busy_o, 0);
    checkOutput("reset done", done_o, 0);
    checkOutput("reset sum", sum_o, 0);
    checkOutput("reset avg", avg_o, 0);
    checkOutput("reset min", min_o, 0);
    checkOutput("reset max", max_o, 0);
    checkOutput("reset bubble", bubble_o, 0);
    checkOutput("reset ovf", ovf_o, 0);
    @(negedge clk) rst_n = 1'b1;

    // Byte 0 is the first launch; expectations are worked by hand
    vecs.push_back('{"uniform3",  32'h07070707, 12, 3, 3, 3, 0, 0});
    vecs.push_back('{"ramp",      32'h1F0F0703, 14, 3, 2, 5, 0, 0});
    vecs.push_back('{"bubble",    32'h07070507, 11, 2, 2, 3, 1, 0});
    vecs.push_back('{"full",      32'hFFFFFFFF, 32, 8, 8, 8, 0, 1});
    vecs.push_back('{"empty",     32'h00000000,  0, 0, 0, 0, 0, 0});
    vecs.push_back('{"mixed",     32'h80FF0001, 10, 2, 0, 8, 1, 1});
    foreach (vecs[i]) runVector(vecs[i]);

    for (int r = 0; r < 10; r++) begin
      for (int k = 0; k < NS; k++) begin
        int t;
        t = $urandom_range(8, 0);
        pats[8*k +: 8] = (t == 8) ? 8'hFF : 8'((1 << t) - 1);
        if ($urandom_range(3, 0) == 0) pats[8*k +: 8] = 8'($urandom);
      end
      runVector(model($sformatf("rand%0d", r), pats));
    end

    repeat (5) @(posedge clk);
    #1;
    checkOutput("idle_hold done", done_o, 0);
    checkOutput("idle_hold max", max_o, model("h", pats).mx);

    // Continuous mode: each DONE cycle acts as the next start edge, so later
    // results arrive LATENCY+1 edges apart; stray start pulses must not disturb it
    v = model("cont", 32'h07070707);
    cont_i = 1'b1;
    applyStimulus(v.pats, lat, got);
    checkResults(v, lat, got);
    for (int r = 0; r < 2; r++) begin
      launch_cycles = 0;
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < 4 * LATENCY) begin
        @(posedge clk);
        cyc++;
        #1;
        start_i = (cyc == 4 || cyc == 13);
        if (done_o) got = 1'b1;
      end
      start_i = 1'b0;
      checkResults(v, cyc - 1, got);
      checkOutput("cont busy", busy_o, 1);
    end
    cont_i = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("cont stop busy", busy_o, 0);

    // Reset during SETTLE of the second launch aborts without a done pulse
    cur_pats = 32'h07070707;
    launch_idx = 0;
    @(negedge clk);
    start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (6) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("midreset launch", launch_o, 0);
    checkOutput("midreset busy", busy_o, 0);
    checkOutput("midreset sum", sum_o, 0);
    checkOutput("midreset avg", avg_o, 0);
    checkOutput("midreset min", min_o, 0);
    checkOutput("midreset max", max_o, 0);
    dones = 0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (done_o) dones++;
    end
    checkOutput("midreset no_done", dones, 0);
    checkOutput("midreset idle", busy_o, 0);
    runVector(model("post_reset", 32'h07070707));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
